alu_seq: RTL and testbench

Sequential RV32I integer ALU sitting directly downstream of the operand-select stage: it consumes the already-muxed `alu_in1`/`alu_in2` operands plus opcode/funct fields and produces a registered result with a start/done handshake. Logic, add/sub and compare ops finish in one cycle. Shifts use a 1-bit-per-cycle serial shifter to save area, so their latency depends on the shift amount.

---
 rtl/alu_seq.sv | 181 ++++++++++++++++++
 tb/tb_alu_seq.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/alu_seq.sv
// alu_seq: sequential RV32I integer ALU with start/done handshake.
// Single-cycle logic/add/compare ops; 1-bit-per-cycle serial shifter.
module alu_seq (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [6:0]  opcode,
    input  logic [2:0]  funct3,
    input  logic        funct7_5,
    input  logic [31:0] alu_in1,
    input  logic [31:0] alu_in2,
    output logic [31:0] result,
    output logic        done,
    output logic        busy
);

    localparam logic [6:0] RISCV_OP     = 7'b0110011;
    localparam logic [6:0] RISCV_OP_IMM = 7'b0010011;
    localparam logic [6:0] RISCV_AUIPC  = 7'b0010111;

    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_SLL  = 3'b001;
    localparam logic [2:0] F3_SLT  = 3'b010;
    localparam logic [2:0] F3_SLTU = 3'b011;
    localparam logic [2:0] F3_XOR  = 3'b100;
    localparam logic [2:0] F3_SR   = 3'b101;
    localparam logic [2:0] F3_OR   = 3'b110;
    localparam logic [2:0] F3_AND  = 3'b111;

    typedef enum logic {
        IDLE,
        SHIFT
    } state_e;

    typedef enum logic [1:0] {
        SH_SLL,
        SH_SRL,
        SH_SRA
    } shkind_e;

    state_e      state_q,  state_d;
    shkind_e     kind_q,   kind_d;
    logic [31:0] work_q,   work_d;
    logic [4:0]  cnt_q,    cnt_d;
    logic [31:0] result_q, result_d;
    logic        done_q,   done_d;

    logic        is_op;
    logic        is_imm;
    logic        is_auipc;
    logic        dec_shift;
    shkind_e     dec_kind;
    logic [4:0]  shamt;
    logic [31:0] fast_res;
    logic [31:0] step_res;

    assign shamt = alu_in2[4:0];

    // Opcode/funct decode and single-cycle result of the incoming request.
    always_comb begin
        is_op     = (opcode == RISCV_OP);
        is_imm    = (opcode == RISCV_OP_IMM);
        is_auipc  = (opcode == RISCV_AUIPC);
        dec_shift = 1'b0;
        dec_kind  = SH_SLL;
        fast_res  = 32'd0;
        if (is_auipc) begin
            fast_res = alu_in1 + alu_in2;
        end else if (is_op || is_imm) begin
            case (funct3)
                F3_ADD: begin
                    if (is_op && funct7_5) begin
                        fast_res = alu_in1 - alu_in2;
                    end else begin
                        fast_res = alu_in1 + alu_in2;
                    end
                end
                F3_SLL: begin
                    dec_shift = 1'b1;
                    dec_kind  = SH_SLL;
                    fast_res  = alu_in1;
                end
                F3_SLT: begin
                    fast_res = {31'd0, $signed(alu_in1) < $signed(alu_in2)};
                end
                F3_SLTU: begin
                    fast_res = {31'd0, alu_in1 < alu_in2};
                end
                F3_XOR: begin
                    fast_res = alu_in1 ^ alu_in2;
                end
                F3_SR: begin
                    dec_shift = 1'b1;
                    dec_kind  = funct7_5 ? SH_SRA : SH_SRL;
                    fast_res  = alu_in1;
                end
                F3_OR: begin
                    fast_res = alu_in1 | alu_in2;
                end
                F3_AND: begin
                    fast_res = alu_in1 & alu_in2;
                end
                default: begin
                    fast_res = 32'd0;
                end
            endcase
        end
    end

    // One-bit move of the working register for the latched shift kind.
    always_comb begin
        step_res = work_q;
        unique case (kind_q)
            SH_SLL:  step_res = {work_q[30:0], 1'b0};
            SH_SRL:  step_res = {1'b0, work_q[31:1]};
            SH_SRA:  step_res = {work_q[31], work_q[31:1]};
            default: step_res = work_q;
        endcase
    end

    // Next-state logic: accept in IDLE, iterate the shifter in SHIFT.
    always_comb begin
        state_d  = state_q;
        kind_d   = kind_q;
        work_d   = work_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        done_d   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    if (dec_shift && (shamt != 5'd0)) begin
                        state_d = SHIFT;
                        kind_d  = dec_kind;
                        work_d  = alu_in1;
                        cnt_d   = shamt;
                    end else begin
                        result_d = fast_res;
                        done_d   = 1'b1;
                    end
                end
            end
            SHIFT: begin
                work_d = step_res;
                cnt_d  = cnt_q - 5'd1;
                if (cnt_q == 5'd1) begin
                    result_d = step_res;
                    done_d   = 1'b1;
                    state_d  = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            kind_q   <= SH_SLL;
            work_q   <= 32'd0;
            cnt_q    <= 5'd0;
            result_q <= 32'd0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            kind_q   <= kind_d;
            work_q   <= work_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            done_q   <= done_d;
        end
    end

    assign result = result_q;
    assign done   = done_q;
    assign busy   = (state_q == SHIFT);

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed and random checks of alu_seq against
// an arithmetic reference model with expected latencies.
module tb_alu_seq;

    localparam logic [6:0] OP    = 7'b0110011;
    localparam logic [6:0] OPIMM = 7'b0010011;
    localparam logic [6:0] AUIPC = 7'b0010111;
    localparam logic [6:0] BADOP = 7'b0000011;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic        funct7_5;
    logic [31:0] alu_in1;
    logic [31:0] alu_in2;
    logic [31:0] result;
    logic        done;
    logic        busy;

    int checks   = 0;
    int failures = 0;

    logic [31:0] exp_res;
    int          exp_lat;

    alu_seq dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .opcode   (opcode),
        .funct3   (funct3),
        .funct7_5 (funct7_5),
        .alu_in1  (alu_in1),
        .alu_in2  (alu_in2),
        .result   (result),
        .done     (done),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] model_res(input logic [6:0] op, input logic [2:0] f3,
                                              input logic f7, input logic [31:0] a,
                                              input logic [31:0] b);
        int sh;
        sh = int'(b[4:0]);
        if (op == AUIPC) return a + b;
        if (op != OP && op != OPIMM) return 32'd0;
        case (f3)
            3'd0: return (op == OP && f7) ? a - b : a + b;
            3'd1: return a << sh;
            3'd2: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            3'd3: return (a < b) ? 32'd1 : 32'd0;
            3'd4: return a ^ b;
            3'd5: return f7 ? 32'($signed(a) >>> sh) : a >> sh;
            3'd6: return a | b;
            default: return a & b;
        endcase
    endfunction

    function automatic int model_lat(input logic [6:0] op, input logic [2:0] f3,
                                     input logic [31:0] b);
        if ((op == OP || op == OPIMM) && (f3 == 3'd1 || f3 == 3'd5))
            return int'(b[4:0]) + 1;
        return 1;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
        end
    endtask

    // Called at a negedge; start is sampled at the following posedge.
    task automatic issue(input logic [6:0] op, input logic [2:0] f3, input logic f7,
                         input logic [31:0] a, input logic [31:0] b);
        opcode   = op;
        funct3   = f3;
        funct7_5 = f7;
        alu_in1  = a;
        alu_in2  = b;
        start    = 1'b1;
        exp_res  = model_res(op, f3, f7, a, b);
        exp_lat  = model_lat(op, f3, b);
        @(posedge clk);
        #1;
        start    = 1'b0;
        opcode   = 7'($urandom);
        funct3   = 3'($urandom);
        funct7_5 = 1'($urandom);
        alu_in1  = $urandom;
        alu_in2  = $urandom;
    endtask

    // Walks the expected latency cycle by cycle; returns at the done negedge.
    task automatic wait_done(input string tag, input bit noise);
        for (int cyc = 1; cyc <= exp_lat; cyc++) begin
            @(negedge clk);
            chk({tag, ".done"}, 32'(done), (cyc == exp_lat) ? 32'd1 : 32'd0);
            chk({tag, ".busy"}, 32'(busy), (cyc < exp_lat) ? 32'd1 : 32'd0);
            if (noise && cyc < exp_lat) begin
                start    = 1'($urandom);
                opcode   = OPIMM;
                funct3   = 3'($urandom);
                funct7_5 = 1'($urandom);
                alu_in1  = $urandom;
                alu_in2  = $urandom;
            end else begin
                start = 1'b0;
            end
        end
        chk({tag, ".result"}, result, exp_res);
    endtask

    initial begin
        reset    = 1'b1;
        start    = 1'b0;
        opcode   = OP;
        funct3   = 3'd0;
        funct7_5 = 1'b0;
        alu_in1  = 32'd0;
        alu_in2  = 32'd0;
        repeat (3) @(negedge clk);
        chk("rst.result", result, 32'd0);
        chk("rst.done", 32'(done), 32'd0);
        chk("rst.busy", 32'(busy), 32'd0);
        reset = 1'b0;
        @(negedge clk);

        issue(OP, 3'd0, 1'b0, 32'd5, 32'd7);
        wait_done("add", 1'b0);
        issue(OP, 3'd0, 1'b1, 32'd3, 32'd5);
        wait_done("sub", 1'b0);
        chk("sub.val", result, 32'hFFFF_FFFE);
        issue(OPIMM, 3'd0, 1'b1, 32'd3, 32'd5);
        wait_done("addi_f7", 1'b0);
        chk("addi_f7.val", result, 32'd8);
        issue(OP, 3'd2, 1'b0, 32'hFFFF_FFFF, 32'd1);
        wait_done("slt", 1'b0);
        chk("slt.val", result, 32'd1);
        issue(OP, 3'd3, 1'b0, 32'hFFFF_FFFF, 32'd1);
        wait_done("sltu", 1'b0);
        chk("sltu.val", result, 32'd0);
        issue(OP, 3'd5, 1'b1, 32'h8000_0000, 32'd4);
        wait_done("sra", 1'b0);
        chk("sra.val", result, 32'hF800_0000);
        issue(OP, 3'd5, 1'b0, 32'h8000_0000, 32'd4);
        wait_done("srl", 1'b0);
        chk("srl.val", result, 32'h0800_0000);
        issue(OP, 3'd1, 1'b0, 32'd1, 32'd31);
        wait_done("sll31", 1'b0);
        chk("sll31.val", result, 32'h8000_0000);
        issue(OPIMM, 3'd1, 1'b0, 32'hDEAD_BEEF, 32'hFFFF_FFE0);
        wait_done("sll0", 1'b0);
        chk("sll0.val", result, 32'hDEAD_BEEF);
        issue(AUIPC, 3'd5, 1'b1, 32'h1000, 32'h2000);
        wait_done("auipc", 1'b0);
        chk("auipc.val", result, 32'h3000);
        issue(BADOP, 3'd0, 1'b0, 32'h1234, 32'h5678);
        wait_done("unsup", 1'b0);
        chk("unsup.val", result, 32'd0);

        issue(OPIMM, 3'd5, 1'b1, 32'h9000_00F0, 32'd12);
        wait_done("sra_noise", 1'b1);
        chk("sra_noise.val", result, 32'hFFF9_0000);
        issue(OP, 3'd1, 1'b0, 32'h0000_0003, 32'd3);
        wait_done("b2b_a", 1'b0);
        issue(OP, 3'd7, 1'b0, 32'hF0F0_1234, 32'h0FF0_FF00);
        wait_done("b2b_b", 1'b0);
        chk("b2b_b.val", result, 32'h00F0_1200);

        issue(OP, 3'd1, 1'b0, 32'h0000_0001, 32'd10);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("midrst.result", result, 32'd0);
        chk("midrst.done", 32'(done), 32'd0);
        chk("midrst.busy", 32'(busy), 32'd0);
        reset = 1'b0;
        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            chk("midrst.nodone", 32'(done), 32'd0);
        end
        issue(OP, 3'd0, 1'b0, 32'd100, 32'd23);
        wait_done("post_rst_add", 1'b0);
        chk("post_rst_add.val", result, 32'd123);

        for (int n = 0; n < 60; n++) begin
            logic [6:0] op;
            logic [31:0] b;
            case ($urandom_range(0, 4))
                0, 1:    op = OP;
                2:       op = OPIMM;
                3:       op = AUIPC;
                default: op = 7'($urandom);
            endcase
            b = $urandom;
            if ($urandom_range(0, 1) == 1) b[4:0] = 5'($urandom_range(0, 6));
            issue(op, 3'($urandom), 1'($urandom), $urandom, b);
            wait_done("rand", 1'($urandom));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
